serial_twos_complement: RTL and testbench

SERIAL_TWOS_COMPLEMENT -- requirements
Module: serial_twos_complement

---
 rtl/twos_complement_pkg.sv | 13 +
 rtl/serial_negate_cell.sv | 26 ++
 rtl/serial_twos_complement.sv | 100 ++++++++++
 tb/tb_serial_twos_complement.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/twos_complement_pkg.sv
// Shared types and defaults for the serial two's complement negator.
// State encodings and the default operand width live here.
package twos_complement_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tc_state_e;

  localparam int TC_WIDTH = 4;

endpackage

// File: rtl/serial_negate_cell.sv
// Per-bit negate cell: copies bits until the first 1 is seen,
// then inverts every following bit.
module serial_negate_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic bit_o
);

  logic seen_one_q;

  assign bit_o = seen_one_q ? ~bit_i : bit_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_one_q <= 1'b0;
    end else if (clr_i) begin
      seen_one_q <= 1'b0;
    end else if (en_i) begin
      seen_one_q <= seen_one_q | bit_i;
    end
  end

endmodule

// File: rtl/serial_twos_complement.sv
// Serial LSB-first two's complement negator with valid/ready handshake.
// Define SERIAL_TWOS_COMPLEMENT_OVF_EN to flag negation of the most negative value.
module serial_twos_complement
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = TC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] In,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  tc_state_e        state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             cell_bit;
  logic             accept;

  assign accept    = (state_q == IDLE) && in_valid;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign Out       = res_q;

  serial_negate_cell u_cell (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (state_q == SHIFT),
    .bit_i (sreg_q[0]),
    .bit_o (cell_bit)
  );

`ifdef SERIAL_TWOS_COMPLEMENT_OVF_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  logic min_q;
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
`ifdef SERIAL_TWOS_COMPLEMENT_OVF_EN
      min_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sreg_q  <= In;
            cnt_q   <= '0;
            state_q <= SHIFT;
`ifdef SERIAL_TWOS_COMPLEMENT_OVF_EN
            min_q   <= (In == MIN_VAL);
`endif
          end
        end
        SHIFT: begin
          sreg_q <= {1'b0, sreg_q[WIDTH-1:1]};
          res_q  <= {cell_bit, res_q[WIDTH-1:1]};
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= DONE;
`ifdef SERIAL_TWOS_COMPLEMENT_OVF_EN
            ovf_q   <= min_q;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
`ifdef SERIAL_TWOS_COMPLEMENT_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_twos_complement.sv
// Directed self-checking bench for serial_twos_complement at WIDTH=4.
module tb_serial_twos_complement;

`ifdef SERIAL_TWOS_COMPLEMENT_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] In;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_twos_complement #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .In        (In),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out       (Out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .ovf       (ovf)
  );

  typedef struct {
    logic [3:0] din;
    logic [3:0] dout;
    logic       dovf;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand, wait for the result, consume it.
  task automatic do_op(input logic [3:0] v, output logic [3:0] res,
                       output logic rov, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    In = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", {busy, in_ready, out_valid}, 3'b100);
    lat = 1;
    tick();
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = Out;
    rov = ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] held;
    logic       o;
    int         lat;
    int         seen;

    vecs[0] = '{4'b0011, 4'b1101, 1'b0};
    vecs[1] = '{4'b0000, 4'b0000, 1'b0};
    vecs[2] = '{4'b0001, 4'b1111, 1'b0};
    vecs[3] = '{4'b0111, 4'b1001, 1'b0};
    vecs[4] = '{4'b1000, 4'b1000, OVF_ON};

    rst = 1'b1;
    In = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("reset_state", {Out, out_valid, busy, ovf}, 7'b0000_000);
    rst = 1'b0;
    #1;
    chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].din, r, o, lat);
      chk($sformatf("vec%0d_out", i), {28'b0, r}, {28'b0, vecs[i].dout});
      chk($sformatf("vec%0d_ovf", i), {31'b0, o}, {31'b0, vecs[i].dovf});
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_idle", i), {in_ready, out_valid, ovf}, 3'b100);
      chk($sformatf("vec%0d_hold", i), {28'b0, Out}, {28'b0, vecs[i].dout});
    end

    // Backpressure: result held while a second operand is offered.
    In = 4'b0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 20) begin
      tick();
      seen++;
    end
    chk("bp_reach_done", {31'b0, out_valid}, 32'd1);
    held = Out;
    chk("bp_result", {28'b0, held}, 32'hb);
    In = 4'b0010;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("bp_hold%0d", c), {Out, out_valid, in_ready, busy},
          {held, 3'b100});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {in_ready, out_valid}, 2'b10);
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid || busy) seen++;
    end
    chk("bp_dropped_operand", seen, 0);

    // Reset in the middle of a conversion.
    In = 4'b0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_async", {Out, out_valid, busy, in_ready}, 7'b0000_001);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_no_result", seen, 0);
    do_op(4'b0110, r, o, lat);
    chk("rst_next_out", {28'b0, r}, 32'ha);
    chk("rst_next_latency", lat, 4);

    // Exhaustive sweep, back-to-back.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      logic [3:0] e;
      v = 4'(i);
      e = 4'(16 - i);
      do_op(v, r, o, lat);
      chk($sformatf("sweep%0d_out", i), {28'b0, r}, {28'b0, e});
      chk($sformatf("sweep%0d_ovf", i), {31'b0, o},
          {31'b0, OVF_ON & (i == 8)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
